// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then arithmetic right shift of {A, Qr, q_m1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] qr,
    input  logic         q_m1,
    input  logic [N:0]   mr,
    output logic [N:0]   a_nxt,
    output logic [N-1:0] qr_nxt,
    output logic         q_m1_nxt
);

    logic [N:0] sum;

    // Booth recoding on {Qr[0], q_m1}, followed by the combined arithmetic shift
    always_comb begin
        sum = a;
        case ({qr[0], q_m1})
            2'b01:   sum = a + mr;
            2'b10:   sum = a - mr;
            default: sum = a;
        endcase
        a_nxt    = {sum[N], sum[N:1]};
        qr_nxt   = {sum[0], qr[N-1:1]};
        q_m1_nxt = qr[0];
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed N x N -> 2N multiplier using radix-2 Booth recoding,
// one Booth step per clock. Handshake: start accepted while ready=1,
// done pulses for one cycle when product updates, valid holds until the
// next accepted start.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           ready,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           valid
);

    localparam int CW = $clog2(N + 1);

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          last_step;

    logic [N:0]    a;
    logic [N-1:0]  qr;
    logic          q_m1;
    logic [N:0]    mr;
    logic [CW-1:0] count;

    logic [N:0]    a_nxt;
    logic [N-1:0]  qr_nxt;
    logic          q_m1_nxt;

    booth_step #(
        .N (N)
    ) u_step (
        .a        (a),
        .qr       (qr),
        .q_m1     (q_m1),
        .mr       (mr),
        .a_nxt    (a_nxt),
        .qr_nxt   (qr_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (count == CW'(N - 1)) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, Booth iteration registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            qr      <= '0;
            q_m1    <= 1'b0;
            mr      <= '0;
            count   <= '0;
            product <= '0;
            valid   <= 1'b0;
        end else if (accept) begin
            a       <= '0;
            qr      <= multiplier;
            q_m1    <= 1'b0;
            mr      <= {multiplicand[N-1], multiplicand};
            count   <= '0;
            valid   <= 1'b0;
        end else if (state == CALC) begin
            a       <= a_nxt;
            qr      <= qr_nxt;
            q_m1    <= q_m1_nxt;
            count   <= count + CW'(1);
            // Final step: result is taken straight from the step outputs
            if (last_step) begin
                product <= {a_nxt[N-1:0], qr_nxt};
                valid   <= 1'b1;
            end
        end
    end

endmodule
